// File: rtl/input_pkg.sv
// Shared types and sizes for the board input conditioner: key FSM states and
// the key/switch counts used by the top level and the bench.
package input_pkg;

   localparam int NUM_KEYS  = 2;
   localparam int NUM_SWS   = 10;
   localparam int REPEAT_CW = 25;

   typedef enum logic [1:0] {
      RELEASED  = 2'd0,
      HELD_WAIT = 2'd1,
      REPEATING = 2'd2
   } key_state_t;

   // Without auto-repeat a key is simply held; this shares the HELD_WAIT encoding.
   localparam key_state_t HELD = HELD_WAIT;

endpackage

// File: rtl/debounce_bit.sv
// One input bit: two-flop synchroniser, stability counter and stable register.
// `toggle` is high on the cycle before `level` takes the synchronised value.
module debounce_bit #(
   parameter int   DB_CYCLES   = 500000,
   parameter logic RESET_VALUE = 1'b0
) (
   input  logic clk_clk,
   input  logic reset_reset,
   input  logic raw,
   output logic level,
   output logic toggle
);

   localparam int CW = $clog2(DB_CYCLES);

   logic          meta;
   logic          sync;
   logic [CW-1:0] count;

   assign toggle = (sync != level) && (count == CW'(DB_CYCLES - 1));

   // NOTE: every flop here uses <= so each one samples the pre-edge values of the others.
   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         meta  <= RESET_VALUE;
         sync  <= RESET_VALUE;
         level <= RESET_VALUE;
         count <= '0;
      end else begin
         meta <= raw;
         sync <= meta;
         if (sync == level) begin
            count <= '0;
         end else if (toggle) begin
            level <= sync;
            count <= '0;
         end else begin
            count <= count + 1'b1;
         end
      end
   end

endmodule

// File: rtl/input_conditioner.sv
// Debounces keys and switches and turns key levels into press/release/repeat
// pulses. Auto-repeat is built only when INPUT_AUTOREPEAT_EN is defined.
module input_conditioner
   import input_pkg::*;
#(
   parameter int DB_CYCLES    = 500000,
   parameter int REPEAT_DELAY = 25000000,
   parameter int REPEAT_RATE  = 5000000
) (
   input  logic                clk_clk,
   input  logic                reset_reset,
   input  logic [NUM_KEYS-1:0] key_raw_n,
   input  logic [NUM_SWS-1:0]  sw_raw,
   output logic [NUM_KEYS-1:0] key_export,
   output logic [NUM_SWS-1:0]  sw_export,
   output logic [NUM_KEYS-1:0] key_press,
   output logic [NUM_KEYS-1:0] key_release,
   output logic [NUM_KEYS-1:0] key_repeat
);

   if (DB_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_params
      $error("input_conditioner: invalid timing parameters");
   end

   logic [NUM_KEYS-1:0] key_toggle;
   logic [NUM_SWS-1:0]  sw_toggle_unused;
   logic [NUM_KEYS-1:0] key_pressing;
   logic [NUM_KEYS-1:0] key_releasing;

   for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
      debounce_bit #(.DB_CYCLES(DB_CYCLES), .RESET_VALUE(1'b1)) u_db (
         .clk_clk     (clk_clk),
         .reset_reset (reset_reset),
         .raw         (key_raw_n[i]),
         .level       (key_export[i]),
         .toggle      (key_toggle[i])
      );
   end

   for (genvar i = 0; i < NUM_SWS; i++) begin : g_sw
      debounce_bit #(.DB_CYCLES(DB_CYCLES), .RESET_VALUE(1'b0)) u_db (
         .clk_clk     (clk_clk),
         .reset_reset (reset_reset),
         .raw         (sw_raw[i]),
         .level       (sw_export[i]),
         .toggle      (sw_toggle_unused[i])
      );
   end

   // Keys are active-low: a toggle from 1 is a press, from 0 a release.
   assign key_pressing  = key_toggle & key_export;
   assign key_releasing = key_toggle & ~key_export;

   key_state_t          state      [NUM_KEYS];
   key_state_t          state_next [NUM_KEYS];
   logic [NUM_KEYS-1:0] press_next;
   logic [NUM_KEYS-1:0] release_next;

`ifdef INPUT_AUTOREPEAT_EN
   logic [REPEAT_CW-1:0] rpt_count      [NUM_KEYS];
   logic [REPEAT_CW-1:0] rpt_count_next [NUM_KEYS];
   logic [NUM_KEYS-1:0]  repeat_next;
`endif

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      for (int k = 0; k < NUM_KEYS; k++) begin
         state_next[k]   = state[k];
         press_next[k]   = 1'b0;
         release_next[k] = 1'b0;
`ifdef INPUT_AUTOREPEAT_EN
         rpt_count_next[k] = rpt_count[k];
         repeat_next[k]    = 1'b0;
`endif
         if (key_releasing[k]) begin
            // Release wins over a repeat expiry landing on the same cycle.
            release_next[k] = 1'b1;
            state_next[k]   = RELEASED;
`ifdef INPUT_AUTOREPEAT_EN
            rpt_count_next[k] = '0;
`endif
         end else begin
            case (state[k])
               RELEASED: begin
                  if (key_pressing[k]) begin
                     press_next[k] = 1'b1;
`ifdef INPUT_AUTOREPEAT_EN
                     state_next[k]     = HELD_WAIT;
                     rpt_count_next[k] = '0;
`else
                     state_next[k] = HELD;
`endif
                  end
               end
`ifdef INPUT_AUTOREPEAT_EN
               HELD_WAIT: begin
                  if (rpt_count[k] == REPEAT_CW'(REPEAT_DELAY - 1)) begin
                     repeat_next[k]    = 1'b1;
                     rpt_count_next[k] = '0;
                     state_next[k]     = REPEATING;
                  end else begin
                     rpt_count_next[k] = rpt_count[k] + 1'b1;
                  end
               end
               REPEATING: begin
                  if (rpt_count[k] == REPEAT_CW'(REPEAT_RATE - 1)) begin
                     repeat_next[k]    = 1'b1;
                     rpt_count_next[k] = '0;
                  end else begin
                     rpt_count_next[k] = rpt_count[k] + 1'b1;
                  end
               end
`endif
               default: ;
            endcase
         end
      end
   end

   // NOTE: the per-key arrays are ordinary flops, not RAM, so they take the async reset too.
   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         for (int k = 0; k < NUM_KEYS; k++) begin
            state[k] <= RELEASED;
`ifdef INPUT_AUTOREPEAT_EN
            rpt_count[k] <= '0;
`endif
         end
         key_press   <= '0;
         key_release <= '0;
`ifdef INPUT_AUTOREPEAT_EN
         key_repeat  <= '0;
`endif
      end else begin
         for (int k = 0; k < NUM_KEYS; k++) begin
            state[k] <= state_next[k];
`ifdef INPUT_AUTOREPEAT_EN
            rpt_count[k] <= rpt_count_next[k];
`endif
         end
         key_press   <= press_next;
         key_release <= release_next;
`ifdef INPUT_AUTOREPEAT_EN
         key_repeat  <= repeat_next;
`endif
      end
   end

`ifndef INPUT_AUTOREPEAT_EN
   assign key_repeat = '0;
`endif

endmodule
